// File: rtl/vec_lsu.sv
// Vector load/store unit: walks the enabled lanes of a strided vector access
// one scalar beat at a time, lowest enabled lane first, stalling the pipeline
// until every lane has been accepted by memory.
module vec_lsu #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   StartM,
    input  logic                   IsStoreM,
    input  logic [ADDR_W-1:0]      BaseAddrM,
    input  logic [ADDR_W-1:0]      StrideM,
    input  logic [LANES-1:0]       MaskM,
    input  logic [LANES*WIDTH-1:0] WriteDataVecM,
    output logic [LANES*WIDTH-1:0] ReadDataVecM,
    output logic                   StallVecM,
    output logic                   DoneM,
    output logic [ADDR_W-1:0]      MemAddr,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic [WIDTH-1:0]       MemWData,
    input  logic [WIDTH-1:0]       MemRData,
    input  logic                   MemReady
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   is_store_q, is_store_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [ADDR_W-1:0]      stride_q, stride_d;
    logic [LANES-1:0]       mask_q, mask_d;
    logic [LANES*WIDTH-1:0] wdata_q, wdata_d;
    logic [LANES*WIDTH-1:0] rdata_q, rdata_d;

    logic [LANE_W-1:0]      lane_idx;
    logic [LANES-1:0]       lane_bit;
    logic [LANES-1:0]       mask_left;
    logic [ADDR_W-1:0]      lane_addr;

    // Pick the lowest still-pending lane; scanning downward lets the lowest set bit win.
    always_comb begin
        lane_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lane_idx = LANE_W'(i);
            end
        end
    end

    assign lane_bit  = LANES'(1) << lane_idx;
    assign mask_left = mask_q & ~lane_bit;
    assign lane_addr = base_q + (ADDR_W'(lane_idx) * stride_q);

    // Next-state logic: capture the request, retire one lane per accepted beat, then pulse done.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        base_d     = base_q;
        stride_d   = stride_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (StartM) begin
                    is_store_d = IsStoreM;
                    base_d     = BaseAddrM;
                    stride_d   = StrideM;
                    mask_d     = MaskM;
                    wdata_d    = WriteDataVecM;
                    rdata_d    = '0;
                    state_d    = (MaskM != '0) ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (MemReady) begin
                    mask_d = mask_left;
                    if (!is_store_q) begin
                        rdata_d[lane_idx*WIDTH +: WIDTH] = MemRData;
                    end
                    if (mask_left == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scalar memory request and handshake outputs, all decoded from registered state.
    always_comb begin
        MemAddr   = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemWData  = '0;
        DoneM     = (state_q == DONE);
        StallVecM = !reset && (((state_q == IDLE) && StartM) || (state_q == ACCESS));
        if (state_q == ACCESS) begin
            MemAddr  = lane_addr;
            MemRead  = !is_store_q;
            MemWrite = is_store_q;
            if (is_store_q) begin
                MemWData = wdata_q[lane_idx*WIDTH +: WIDTH];
            end
        end
    end

    assign ReadDataVecM = rdata_q;

    // State registers; reset aborts any in-flight operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            base_q     <= '0;
            stride_q   <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_vec_lsu.sv
// Directed testbench for vec_lsu: table of whole operations plus hand-written
// sequences for memory back-pressure and reset in the middle of an access.
module tb_vec_lsu;

    logic         clk;
    logic         reset;
    logic         StartM;
    logic         IsStoreM;
    logic [31:0]  BaseAddrM;
    logic [31:0]  StrideM;
    logic [3:0]   MaskM;
    logic [127:0] WriteDataVecM;
    logic [127:0] ReadDataVecM;
    logic         StallVecM;
    logic         DoneM;
    logic [31:0]  MemAddr;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  MemWData;
    logic [31:0]  MemRData;
    logic         MemReady;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic         is_store;
        logic [31:0]  base;
        logic [31:0]  stride;
        logic [3:0]   mask;
        logic [127:0] wdata;
        int           count;
        logic [127:0] exp_addr;
        logic [127:0] exp_wdata;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    vec_lsu #(.LANES(4), .WIDTH(32), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .StartM        (StartM),
        .IsStoreM      (IsStoreM),
        .BaseAddrM     (BaseAddrM),
        .StrideM       (StrideM),
        .MaskM         (MaskM),
        .WriteDataVecM (WriteDataVecM),
        .ReadDataVecM  (ReadDataVecM),
        .StallVecM     (StallVecM),
        .DoneM         (DoneM),
        .MemAddr       (MemAddr),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemWData      (MemWData),
        .MemRData      (MemRData),
        .MemReady      (MemReady)
    );

    // Memory model returns the requested address as read data.
    assign MemRData = MemAddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_rd"}, 128'(MemRead), 128'd0);
        checkOutput({tag, "_wr"}, 128'(MemWrite), 128'd0);
        checkOutput({tag, "_addr"}, 128'(MemAddr), 128'd0);
        checkOutput({tag, "_wdata"}, 128'(MemWData), 128'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        StartM        = 1'b1;
        IsStoreM      = v.is_store;
        BaseAddrM     = v.base;
        StrideM       = v.stride;
        MaskM         = v.mask;
        WriteDataVecM = v.wdata;
        #2;
        checkOutput({tag, "_stall_c0"}, 128'(StallVecM), 128'd1);
        nextCycle();
        StartM        = 1'b0;
        WriteDataVecM = '0;
        for (int k = 0; k < v.count; k++) begin
            #2;
            checkOutput($sformatf("%s_addr%0d", tag, k), 128'(MemAddr), 128'(v.exp_addr[k*32 +: 32]));
            checkOutput($sformatf("%s_wdata%0d", tag, k), 128'(MemWData), 128'(v.exp_wdata[k*32 +: 32]));
            checkOutput($sformatf("%s_wr%0d", tag, k), 128'(MemWrite), 128'(v.is_store));
            checkOutput($sformatf("%s_rd%0d", tag, k), 128'(MemRead), 128'(!v.is_store));
            checkOutput($sformatf("%s_stall%0d", tag, k), 128'(StallVecM), 128'd1);
            checkOutput($sformatf("%s_done%0d", tag, k), 128'(DoneM), 128'd0);
            nextCycle();
        end
        #2;
        checkOutput({tag, "_done"}, 128'(DoneM), 128'd1);
        checkOutput({tag, "_stall_done"}, 128'(StallVecM), 128'd0);
        checkQuiet({tag, "_donecyc"});
        nextCycle();
        #2;
        checkOutput({tag, "_done_gone"}, 128'(DoneM), 128'd0);
        checkOutput({tag, "_rdata"}, ReadDataVecM, v.exp_rdata);
        nextCycle();
        checkOutput({tag, "_rdata_hold"}, ReadDataVecM, v.exp_rdata);
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        StartM        = 1'b1;
        IsStoreM      = 1'b1;
        BaseAddrM     = 32'h100;
        StrideM       = 32'h4;
        MaskM         = 4'hF;
        WriteDataVecM = '0;
        MemReady      = 1'b1;

        // store, unit-ish stride, all lanes
        vecs[0] = '{1'b1, 32'h100, 32'h4, 4'b1111,
                    {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000}, 4,
                    {32'h10C, 32'h108, 32'h104, 32'h100},
                    {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000},
                    128'd0};
        // load, stride 8, lanes 0 and 2
        vecs[1] = '{1'b0, 32'h200, 32'h8, 4'b0101,
                    {4{32'h11111111}}, 2,
                    {32'h0, 32'h0, 32'h210, 32'h200},
                    128'd0,
                    {32'h0, 32'h210, 32'h0, 32'h200}};
        // empty mask: straight to done, read data cleared
        vecs[2] = '{1'b0, 32'h400, 32'h4, 4'b0000,
                    128'd0, 0, 128'd0, 128'd0, 128'd0};
        // address wrap-around
        vecs[3] = '{1'b1, 32'hFFFFFFFC, 32'h4, 4'b0011,
                    {32'h55555555, 32'h55555555, 32'hBEEF0001, 32'hBEEF0000}, 2,
                    {32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFC},
                    {32'h0, 32'h0, 32'hBEEF0001, 32'hBEEF0000},
                    128'd0};
        // load, odd lanes only
        vecs[4] = '{1'b0, 32'h40, 32'h10, 4'b1010,
                    128'd0, 2,
                    {32'h0, 32'h0, 32'h70, 32'h50},
                    128'd0,
                    {32'h70, 32'h0, 32'h50, 32'h0}};

        #3;
        checkOutput("reset_stall", 128'(StallVecM), 128'd0);
        checkOutput("reset_done", 128'(DoneM), 128'd0);
        checkOutput("reset_rdata", ReadDataVecM, 128'd0);
        checkQuiet("reset");
        StartM = 1'b0;
        nextCycle();
        reset = 1'b0;
        nextCycle();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Back-pressure: lane 0 held off for three cycles
        StartM        = 1'b1;
        IsStoreM      = 1'b1;
        BaseAddrM     = 32'h300;
        StrideM       = 32'h4;
        MaskM         = 4'b0011;
        WriteDataVecM = {32'h0, 32'h0, 32'h77770001, 32'h77770000};
        nextCycle();
        StartM   = 1'b0;
        MemReady = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #2;
            checkOutput($sformatf("bp_addr_c%0d", c), 128'(MemAddr), 128'h300);
            checkOutput($sformatf("bp_wdata_c%0d", c), 128'(MemWData), 128'h77770000);
            checkOutput($sformatf("bp_wr_c%0d", c), 128'(MemWrite), 128'd1);
            checkOutput($sformatf("bp_done_c%0d", c), 128'(DoneM), 128'd0);
            nextCycle();
        end
        MemReady = 1'b1;
        #2;
        checkOutput("bp_addr_c4", 128'(MemAddr), 128'h300);
        nextCycle();
        #2;
        checkOutput("bp_addr_c5", 128'(MemAddr), 128'h304);
        checkOutput("bp_wdata_c5", 128'(MemWData), 128'h77770001);
        checkOutput("bp_done_c5", 128'(DoneM), 128'd0);
        nextCycle();
        #2;
        checkOutput("bp_done_c6", 128'(DoneM), 128'd1);
        nextCycle();
        nextCycle();

        // Reset during lane 1 of a four-lane store
        StartM        = 1'b1;
        IsStoreM      = 1'b1;
        BaseAddrM     = 32'h100;
        StrideM       = 32'h4;
        MaskM         = 4'b1111;
        WriteDataVecM = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        nextCycle();
        StartM = 1'b0;
        nextCycle();
        #2;
        checkOutput("rst_lane1_addr", 128'(MemAddr), 128'h104);
        reset = 1'b1;
        #1;
        checkOutput("rst_stall", 128'(StallVecM), 128'd0);
        checkOutput("rst_done", 128'(DoneM), 128'd0);
        checkQuiet("rst_now");
        nextCycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checkOutput($sformatf("rst_after_wr%0d", c), 128'(MemWrite), 128'd0);
            checkOutput($sformatf("rst_after_stall%0d", c), 128'(StallVecM), 128'd0);
            nextCycle();
        end
        applyStimulus(vecs[1], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_lsu.md
VEC_LSU -- requirements
Module: vec_lsu

Interface
REQ-001 SHALL have parameter LANES, default 4, number of vector lanes (1..16).
REQ-002 SHALL have parameter WIDTH, default 32, lane data width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port StartM  input  1  vector memory op request from the M stage.
REQ-007 SHALL have port IsStoreM  input  1  1 = vector store, 0 = vector load.
REQ-008 SHALL have port BaseAddrM  input  ADDR_W  byte address of lane 0.
REQ-009 SHALL have port StrideM  input  ADDR_W  byte stride between consecutive lanes.
REQ-010 SHALL have port MaskM  input  LANES  per-lane enable; bit i enables lane i.
REQ-011 SHALL have port WriteDataVecM  input  LANES*WIDTH  store data, lane i at bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port ReadDataVecM  output  LANES*WIDTH  load result, same packing.
REQ-013 SHALL have port StallVecM  output  1  pipeline stall request.
REQ-014 SHALL have port DoneM  output  1  one-cycle completion pulse.
REQ-015 SHALL have ports MemAddr (output, ADDR_W), MemRead (output, 1), MemWrite (output, 1), MemWData (output, WIDTH): scalar memory request.
REQ-016 SHALL have ports MemRData (input, WIDTH) and MemReady (input, 1): read data, and beat acceptance in the same cycle.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-018 In IDLE with StartM=1, SHALL capture IsStoreM, BaseAddrM, StrideM, MaskM, WriteDataVecM into internal registers and clear ReadDataVecM to 0.
REQ-019 From IDLE, SHALL move to ACCESS if captured mask is nonzero, else directly to DONE.
REQ-020 In ACCESS, current lane SHALL be the lowest set bit of the remaining-mask register; masked-off lanes consume zero cycles.
REQ-021 In ACCESS, SHALL drive MemAddr = base + lane*stride, truncated modulo 2^ADDR_W (wrap-around, no error).
REQ-022 In ACCESS, SHALL assert MemWrite (store) or MemRead (load), never both; MemWData = captured lane data on store, 0 on load.
REQ-023 On a cycle with MemReady=1 in ACCESS, SHALL clear the current lane's bit in the remaining mask; for loads, SHALL write MemRData into that lane of ReadDataVecM.
REQ-024 When MemReady=1 retires the last remaining lane, SHALL move to DONE at the next edge.
REQ-025 While MemReady=0, MemAddr, MemRead, MemWrite, MemWData SHALL hold stable and no state SHALL change.
REQ-026 In DONE, SHALL assert DoneM=1 for exactly one cycle, then return to IDLE; ReadDataVecM SHALL hold until the next accepted StartM.
REQ-027 StallVecM SHALL equal (IDLE and StartM) or ACCESS, combinationally; it SHALL be 0 in DONE.
REQ-028 StartM SHALL be ignored in ACCESS and DONE.
REQ-029 Latency: with MemReady tied high and N enabled lanes, DoneM SHALL assert in cycle N+1 after the capture edge (cycle 1 for N=0).
REQ-030 MemRead, MemWrite, DoneM SHALL be 0 in IDLE and DONE.

Reset
REQ-031 On reset=1, at any time including mid-ACCESS, SHALL enter IDLE immediately, clear all captured registers and ReadDataVecM to 0, and drive MemRead=MemWrite=DoneM=StallVecM=0, MemAddr=0, MemWData=0.
REQ-032 After reset deassertion, the first StartM SHALL be accepted normally; no lane of an aborted op SHALL be issued.

Verification
REQ-033 LANES=4, store, base 0x100, stride 4, mask 1111, MemReady=1 -> MemWrite with addresses 0x100,0x104,0x108,0x10C in cycles 1-4, DoneM in cycle 5, StallVecM high cycles 0-4.
REQ-034 Load, base 0x200, stride 8, mask 0101, MemRData = address -> MemRead at 0x200, 0x210 in cycles 1-2; DoneM cycle 3; ReadDataVecM lanes = {0, 0x210, 0, 0x200} (lane3..lane0).
REQ-035 Mask 0000 with StartM -> no MemRead/MemWrite; DoneM in cycle 1; ReadDataVecM = 0.
REQ-036 Store mask 0011, MemReady low for 3 cycles on lane 0 -> MemAddr/MemWData stable those cycles; DoneM delayed by exactly 3 cycles (cycle 6).
REQ-037 Base 0xFFFFFFFC, stride 4, mask 0011 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-038 Assert reset during lane 1 of a 4-lane store -> outputs zero in the same cycle; lanes 2-3 never issued; subsequent StartM completes normally.
